// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state, opcode and datapath-select encodings for the multicycle control unit
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_AUIPC     = 4'd9,
    S_BRANCH    = 4'd10,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_CONST4 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  // Dispatch from DECODE; anything outside the supported opcode set traps.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEM_ADDR;
      OP_OP:             return S_EXEC_R;
      OP_OPIMM:          return S_EXEC_I;
      OP_AUIPC:          return S_AUIPC;
      OP_BRANCH:         return S_BRANCH;
      default:           return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_output_decoder.sv
// rtl/control_output_decoder.sv - maps the current state (plus zero/ready) to every control output
module control_output_decoder
  import control_pkg::*;
(
  input  state_t     state_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       i_or_d_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       illegal_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    i_or_d_o     = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_RS2;
    alu_op_o     = ALU_ADD;
    result_src_o = RES_ALU_OUT;
    illegal_o    = 1'b0;
    case (state_i)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_CONST4;
        alu_op_o     = ALU_ADD;
        result_src_o = RES_ALU_RESULT;
        // IR and PC+4 only commit on the cycle the fetch actually completes
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_MEM_WB: begin
        result_src_o = RES_MEM_DATA;
        reg_write_o  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_o   = 1'b1;
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_FUNCT;
      end
      S_AUIPC: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
      end
      S_ALU_WB: begin
        result_src_o = RES_ALU_OUT;
        reg_write_o  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o  = SRC_A_RS1;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = ALU_SUB;
        result_src_o = RES_ALU_OUT;
        // BNE: redirect to the target precomputed in DECODE when operands differ
        pc_write_o   = ~zero_i;
      end
      S_ILLEGAL: illegal_o = 1'b1;
      default:   illegal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32 subset control FSM with retire counter
module multicycle_control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        i_or_d_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  result_src_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] retired_o
);

  state_t      r_state;
  logic [31:0] r_retired;

  logic w_mem_write;
  logic w_ir_write;
  logic w_pc_write;
  logic w_reg_write;

  // The counter is only written on a retire so its value holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH:     if (mem_ready_i) r_state <= S_DECODE;
        S_DECODE:    r_state <= decode_next(op_i);
        S_MEM_ADDR: begin
          if (op_i == OP_LOAD)       r_state <= S_MEM_READ;
          else if (op_i == OP_STORE) r_state <= S_MEM_WRITE;
          else                       r_state <= S_ILLEGAL;
        end
        S_MEM_READ:  if (mem_ready_i) r_state <= S_MEM_WB;
        S_MEM_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 32'd1;
        end
        S_MEM_WRITE: begin
          if (mem_ready_i) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + 32'd1;
          end
        end
        S_EXEC_R, S_EXEC_I, S_AUIPC: r_state <= S_ALU_WB;
        S_ALU_WB, S_BRANCH: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 32'd1;
        end
        S_ILLEGAL:   r_state <= S_ILLEGAL;
        default:     r_state <= S_ILLEGAL;
      endcase
    end
  end

  control_output_decoder u_decoder (
    .state_i      (r_state),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .i_or_d_o     (i_or_d_o),
    .mem_write_o  (w_mem_write),
    .ir_write_o   (w_ir_write),
    .pc_write_o   (w_pc_write),
    .reg_write_o  (w_reg_write),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .illegal_o    (illegal_o)
  );

  // Architectural side effects are suppressed for the whole reset cycle,
  // even though FETCH with mem_ready_i high would otherwise commit.
  assign mem_write_o = w_mem_write & ~reset;
  assign ir_write_o  = w_ir_write  & ~reset;
  assign pc_write_o  = w_pc_write  & ~reset;
  assign reg_write_o = w_reg_write & ~reset;

  assign state_o   = r_state;
  assign retired_o = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op_i = 7'h00;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        mem_req_o, i_or_d_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic        illegal_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .op_i         (op_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .i_or_d_o     (i_or_d_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .result_src_o (result_src_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  always #5 clk = ~clk;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
  localparam int ER = 6, EI = 7, AWB = 8, AU = 9, BR = 10, IL = 15;

  typedef struct {
    int   st;
    logic rdy;
  } step_t;

  step_t       seq[$];
  bit          seq_retires;
  logic [31:0] m_retired;
  int          n_checks = 0;
  int          n_errors = 0;

  wire [14:0] w_obs = {mem_req_o, i_or_d_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o,
                       alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, illegal_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control-signal table read straight off the per-state output lists.
  function automatic logic [14:0] exp_out(input int st, input logic rdy, input logic z);
    logic req, iord, mw, irw, pcw, rw, ill;
    logic [1:0] a, b, alu, res;
    {req, iord, mw, irw, pcw, rw, ill} = '0;
    {a, b, alu, res} = '0;
    case (st)
      FE:  begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      DE:  begin a = 2'b01; b = 2'b01; end
      MA:  begin a = 2'b10; b = 2'b01; end
      MR:  begin req = 1; iord = 1; end
      MWB: begin res = 2'b01; rw = 1; end
      MW:  begin req = 1; iord = 1; mw = 1; end
      ER:  begin a = 2'b10; b = 2'b00; alu = 2'b10; end
      EI:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      AU:  begin a = 2'b01; b = 2'b01; end
      AWB: begin rw = 1; end
      BR:  begin a = 2'b10; alu = 2'b01; pcw = ~z; end
      IL:  begin ill = 1; end
      default: ;
    endcase
    return {req, iord, mw, irw, pcw, rw, a, b, alu, res, ill};
  endfunction

  task automatic push(input int st, input logic rdy);
    step_t s;
    s.st  = st;
    s.rdy = rdy;
    seq.push_back(s);
  endtask

  // Expected per-cycle state walk for one instruction with the given wait counts.
  task automatic build(input logic [6:0] op, input int wf, input int wm);
    seq.delete();
    seq_retires = 1;
    repeat (wf) push(FE, 1'b0);
    push(FE, 1'b1);
    push(DE, 1'($urandom));
    case (op)
      7'h03: begin
        push(MA, 1'($urandom));
        repeat (wm) push(MR, 1'b0);
        push(MR, 1'b1);
        push(MWB, 1'($urandom));
      end
      7'h23: begin
        push(MA, 1'($urandom));
        repeat (wm) push(MW, 1'b0);
        push(MW, 1'b1);
      end
      7'h33: begin push(ER, 1'($urandom)); push(AWB, 1'($urandom)); end
      7'h13: begin push(EI, 1'($urandom)); push(AWB, 1'($urandom)); end
      7'h17: begin push(AU, 1'($urandom)); push(AWB, 1'($urandom)); end
      7'h63: push(BR, 1'($urandom));
      default: begin
        seq_retires = 0;
        repeat (3) push(IL, 1'($urandom));
      end
    endcase
  endtask

  // Starts and ends just after a falling edge; n < 0 runs the whole sequence.
  task automatic run_seq(input int n);
    int lim;
    lim = (n < 0) ? seq.size() : n;
    for (int i = 0; i < lim; i++) begin
      mem_ready_i = seq[i].rdy;
      #1;
      check("state", 32'(state_o), 32'(seq[i].st));
      check("ctrl", 32'(w_obs), 32'(exp_out(seq[i].st, seq[i].rdy, zero_i)));
      check("retired", retired_o, m_retired);
      @(posedge clk);
      @(negedge clk);
    end
    if (n < 0 && seq_retires) m_retired = m_retired + 32'd1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm);
    op_i   = op;
    zero_i = z;
    build(op, wf, wm);
    run_seq(-1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    check("rst_strobes", 32'({mem_write_o, reg_write_o, pc_write_o, ir_write_o}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_retired = '0;
    #1;
    check("rst_state", 32'(state_o), 32'(FE));
    check("rst_illegal", 32'(illegal_o), 32'h0);
    check("rst_retired", retired_o, 32'h0);
  endtask

  logic [6:0] legal_ops [6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h17, 7'h63};

  initial begin
    m_retired = '0;
    @(negedge clk);
    do_reset();

    // LW with no waits, then SW with two stalled store cycles
    run_instr(7'h03, 1'b0, 0, 0);
    check("lw_retired", retired_o, 32'd1);
    run_instr(7'h23, 1'b0, 0, 2);
    check("sw_retired", retired_o, 32'd2);

    // BNE taken and not taken
    run_instr(7'h63, 1'b0, 0, 0);
    run_instr(7'h63, 1'b1, 0, 0);

    // Trap on unsupported opcode, counter frozen, reset clears the trap
    run_instr(7'h7F, 1'b0, 1, 0);
    check("illegal_sticky", 32'(illegal_o), 32'h1);
    do_reset();

    // Counter wrap through ADDI
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_retired = 32'hFFFF_FFFF;
    run_instr(7'h13, 1'b0, 0, 0);
    check("wrap", retired_o, 32'h0);

    // Reset landing while LW waits in MEM_READ
    op_i = 7'h03;
    build(7'h03, 0, 3);
    run_seq(4);
    check("mid_read_state", 32'(state_o), 32'(MR));
    do_reset();
    mem_ready_i = 1'b1;
    #1;
    check("no_wb_after_rst", 32'(reg_write_o), 32'h0);

    for (int k = 0; k < 40; k++) begin
      int r;
      logic [6:0] op;
      r  = $urandom_range(0, 13);
      op = (r < 12) ? legal_ops[r % 6] : ((r == 12) ? 7'h00 : 7'h6F);
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      if (r >= 12) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
